// File: rtl/zorro_bus_master_if.sv
// Local request port of zorro_bus_master: one single-word request plus its completion status.
// The requester (test sequencer / config walker) uses the master modport, the bus engine the slave modport.
interface zorro_bus_master_if;
  logic        req;
  logic        req_rw;
  logic [23:1] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_be;
  logic        busy;
  logic        ack;
  logic [15:0] rdata;
  logic        err;
  logic        tmo;

  modport master (
    output req, req_rw, req_addr, req_wdata, req_be,
    input  busy, ack, rdata, err, tmo
  );

  modport slave (
    input  req, req_rw, req_addr, req_wdata, req_be,
    output busy, ack, rdata, err, tmo
  );
endinterface

// File: rtl/zorro_bus_master.sv
// Zorro II / 68000-style bus cycle initiator: turns single-word local requests into AS_n/UDS_n/LDS_n cycles.
// Define BUS_TIMEOUT_EN to abort WAIT after TIMEOUT_CYCLES clocks with err=1, tmo=1; otherwise WAIT holds forever.
module zorro_bus_master
  #(parameter int unsigned TIMEOUT_CYCLES = 255)
  (
  input  logic              CLK,
  input  logic              RESET,
  zorro_bus_master_if.slave ctrl,
  output logic [23:1]       ADDR,
  output logic              ADDR_OE,
  output logic              AS_n,
  output logic              UDS_n,
  output logic              LDS_n,
  output logic              RW,
  output logic [15:0]       DOUT,
  output logic              DOUT_OE,
  input  logic [15:0]       DIN,
  input  logic              DTACK_n,
  input  logic              BERR_n
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ASSERT, S_WAIT, S_DATA, S_END, S_RECOVER
  } state_t;

  state_t      state, state_d;
  logic        accept;
  logic        rw_q, rw_d;
  logic [1:0]  be_q, be_d;
  logic [15:0] rdata_q;
  logic        err_q, err_d;
  logic        busy_q, ack_q;
  logic        dtack_s1, dtack_s2, berr_s1, berr_s2;
  logic [1:0]  wait_cnt;
  logic        term_ok;
  logic        timeout_hit;
  logic        addr_oe_d, as_n_d, uds_n_d, lds_n_d, rw_pin_d, dout_oe_d, ack_d, busy_d;

  assign accept  = (state == S_IDLE) && ctrl.req;
  assign rw_d    = accept ? ctrl.req_rw : rw_q;
  assign be_d    = accept ? ctrl.req_be : be_q;
  // Terminations are only honoured from the third WAIT clock, which keeps AS_n low for at least 5 clocks.
  assign term_ok = (wait_cnt == 2'd2);

`ifdef BUS_TIMEOUT_EN
  logic [7:0] tmo_cnt;
  logic       tmo_q, tmo_d;

  assign timeout_hit = (({1'b0, tmo_cnt} + 9'd1) == 9'(TIMEOUT_CYCLES));
  assign ctrl.tmo    = tmo_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      tmo_cnt <= '0;
      tmo_q   <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      if (state == S_ASSERT)
        tmo_cnt <= '0;
      else if (state == S_WAIT)
        tmo_cnt <= tmo_cnt + 8'd1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign ctrl.tmo    = 1'b0;
`endif

  always_comb begin
    state_d = state;
    err_d   = err_q;
`ifdef BUS_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif
    unique case (state)
      S_IDLE: begin
        if (ctrl.req) begin
          err_d = 1'b0;
`ifdef BUS_TIMEOUT_EN
          tmo_d = 1'b0;
`endif
          // An all-zero byte enable completes at once without touching the bus.
          state_d = (ctrl.req_be == 2'b00) ? S_RECOVER : S_ADDR;
        end
      end
      S_ADDR:   state_d = S_ASSERT;
      S_ASSERT: state_d = S_WAIT;
      S_WAIT: begin
        if (term_ok && !berr_s2) begin
          err_d   = 1'b1;
          state_d = S_END;
        end else if (term_ok && !dtack_s2) begin
          state_d = S_DATA;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
`ifdef BUS_TIMEOUT_EN
          tmo_d   = 1'b1;
`endif
          state_d = S_END;
        end
      end
      S_DATA:    state_d = S_END;
      S_END:     state_d = S_RECOVER;
      S_RECOVER: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    // Pin values are decoded for the state being entered so they register glitch-free with it.
    addr_oe_d = 1'b0;
    as_n_d    = 1'b1;
    uds_n_d   = 1'b1;
    lds_n_d   = 1'b1;
    rw_pin_d  = 1'b1;
    dout_oe_d = 1'b0;
    ack_d     = 1'b0;
    busy_d    = 1'b1;
    unique case (state_d)
      S_IDLE: busy_d = 1'b0;
      S_ADDR: begin
        addr_oe_d = 1'b1;
        rw_pin_d  = rw_d;
      end
      S_ASSERT: begin
        addr_oe_d = 1'b1;
        rw_pin_d  = rw_d;
        as_n_d    = 1'b0;
        if (rw_d) begin
          uds_n_d = ~be_d[1];
          lds_n_d = ~be_d[0];
        end else begin
          dout_oe_d = 1'b1;
        end
      end
      S_WAIT, S_DATA: begin
        addr_oe_d = 1'b1;
        rw_pin_d  = rw_d;
        as_n_d    = 1'b0;
        uds_n_d   = ~be_d[1];
        lds_n_d   = ~be_d[0];
        dout_oe_d = ~rw_d;
      end
      S_END: begin
        addr_oe_d = 1'b1;
        rw_pin_d  = rw_d;
        dout_oe_d = ~rw_d;
      end
      S_RECOVER: ack_d = 1'b1;
      default:   busy_d = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= S_IDLE;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      ADDR_OE <= 1'b0;
      AS_n    <= 1'b1;
      UDS_n   <= 1'b1;
      LDS_n   <= 1'b1;
      RW      <= 1'b1;
      DOUT_OE <= 1'b0;
    end else begin
      state   <= state_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      ADDR_OE <= addr_oe_d;
      AS_n    <= as_n_d;
      UDS_n   <= uds_n_d;
      LDS_n   <= lds_n_d;
      RW      <= rw_pin_d;
      DOUT_OE <= dout_oe_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      dtack_s1 <= 1'b1;
      dtack_s2 <= 1'b1;
      berr_s1  <= 1'b1;
      berr_s2  <= 1'b1;
      ADDR     <= '0;
      DOUT     <= '0;
      rw_q     <= 1'b1;
      be_q     <= 2'b00;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      wait_cnt <= 2'd0;
    end else begin
      dtack_s1 <= DTACK_n;
      dtack_s2 <= dtack_s1;
      berr_s1  <= BERR_n;
      berr_s2  <= berr_s1;
      err_q    <= err_d;
      rw_q     <= rw_d;
      be_q     <= be_d;
      if (accept) begin
        ADDR <= ctrl.req_addr;
        DOUT <= ctrl.req_wdata;
      end
      if (state == S_DATA && rw_q)
        rdata_q <= DIN;
      if (state == S_ASSERT)
        wait_cnt <= 2'd0;
      else if (state == S_WAIT && wait_cnt != 2'd2)
        wait_cnt <= wait_cnt + 2'd1;
    end
  end

  assign ctrl.busy  = busy_q;
  assign ctrl.ack   = ack_q;
  assign ctrl.rdata = rdata_q;
  assign ctrl.err   = err_q;

endmodule

// File: tb/tb_zorro_bus_master.sv
// Scoreboard bench for zorro_bus_master: requests push expected ack cycle/rdata/err/tmo, a monitor pops on ack.
// Build with BUS_TIMEOUT_EN defined to also exercise the timeout abort with TIMEOUT_CYCLES=16.
module tb_zorro_bus_master;
  logic        CLK = 1'b0;
  logic        RESET;
  logic [23:1] ADDR;
  logic        ADDR_OE, AS_n, UDS_n, LDS_n, RW, DOUT_OE;
  logic [15:0] DOUT;
  logic [15:0] DIN;
  logic        DTACK_n, BERR_n;

  int cyc        = 0;
  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    int          cyc;
    logic [15:0] rdata;
    logic        err;
    logic        tmo;
  } exp_t;
  exp_t exp_q[$];

  zorro_bus_master_if bif();

  zorro_bus_master #(.TIMEOUT_CYCLES(16)) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .ctrl    (bif.slave),
    .ADDR    (ADDR),
    .ADDR_OE (ADDR_OE),
    .AS_n    (AS_n),
    .UDS_n   (UDS_n),
    .LDS_n   (LDS_n),
    .RW      (RW),
    .DOUT    (DOUT),
    .DOUT_OE (DOUT_OE),
    .DIN     (DIN),
    .DTACK_n (DTACK_n),
    .BERR_n  (BERR_n)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Waits for the falling edge inside cycle c (cycles count rising edges since time 0).
  task automatic atCycle(input int c);
    @(negedge CLK);
    while (cyc < c) @(negedge CLK);
  endtask

  task automatic applyStimulus(input logic rw, input logic [23:1] addr, input logic [15:0] wdata,
                               input logic [1:0] be, input bit expect_ack, input int latency,
                               input logic [15:0] exp_rdata, input logic exp_err, input logic exp_tmo,
                               output int c0);
    exp_t e;
    @(posedge CLK);
    #1;
    c0             = cyc;
    bif.req        = 1'b1;
    bif.req_rw     = rw;
    bif.req_addr   = addr;
    bif.req_wdata  = wdata;
    bif.req_be     = be;
    if (expect_ack) begin
      e.cyc   = c0 + latency;
      e.rdata = exp_rdata;
      e.err   = exp_err;
      e.tmo   = exp_tmo;
      exp_q.push_back(e);
    end
    @(posedge CLK);
    #1;
    bif.req = 1'b0;
  endtask

  always @(negedge CLK) begin : monitor
    exp_t e;
    if (bif.ack === 1'b1) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_ack: got ack=1, expected ack=0 (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        checkOutput("ack_cycle", cyc, e.cyc);
        checkOutput("ack_rdata", bif.rdata, e.rdata);
        checkOutput("ack_err", bif.err, e.err);
        checkOutput("ack_tmo", bif.tmo, e.tmo);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int c0;
    RESET         = 1'b1;
    DTACK_n       = 1'b1;
    BERR_n        = 1'b1;
    DIN           = 16'h0000;
    bif.req       = 1'b0;
    bif.req_rw    = 1'b1;
    bif.req_addr  = '0;
    bif.req_wdata = '0;
    bif.req_be    = 2'b00;

    repeat (3) @(negedge CLK);
    checkOutput("rst_busy", bif.busy, 0);
    checkOutput("rst_ack", bif.ack, 0);
    checkOutput("rst_err", bif.err, 0);
    checkOutput("rst_tmo", bif.tmo, 0);
    checkOutput("rst_rdata", bif.rdata, 0);
    checkOutput("rst_addr", ADDR, 0);
    checkOutput("rst_addr_oe", ADDR_OE, 0);
    checkOutput("rst_strobes", {AS_n, UDS_n, LDS_n}, 3'b111);
    checkOutput("rst_rw", RW, 1);
    checkOutput("rst_dout", DOUT, 0);
    checkOutput("rst_dout_oe", DOUT_OE, 0);
    RESET = 1'b0;
    repeat (2) @(negedge CLK);

    // Read with DTACK_n tied low: minimum 8-clock cycle
    DTACK_n = 1'b0;
    DIN     = 16'hC0DE;
    repeat (2) @(negedge CLK);
    applyStimulus(1'b1, 23'h740000, 16'h0000, 2'b11, 1'b1, 8, 16'hC0DE, 1'b0, 1'b0, c0);
    atCycle(c0 + 1);
    checkOutput("rd_addr_phase_oe", ADDR_OE, 1);
    checkOutput("rd_addr_phase_addr", ADDR, 23'h740000);
    checkOutput("rd_addr_phase_as", AS_n, 1);
    checkOutput("rd_busy", bif.busy, 1);
    atCycle(c0 + 2);
    checkOutput("rd_assert_strobes", {AS_n, UDS_n, LDS_n}, 3'b000);
    checkOutput("rd_assert_dout_oe", DOUT_OE, 0);
    checkOutput("rd_assert_rw", RW, 1);
    atCycle(c0 + 6);
    checkOutput("rd_data_as", AS_n, 0);
    atCycle(c0 + 7);
    checkOutput("rd_end_as", AS_n, 1);
    checkOutput("rd_end_addr_oe", ADDR_OE, 1);
    atCycle(c0 + 8);
    checkOutput("rd_recover_addr_oe", ADDR_OE, 0);
    @(negedge CLK);
    DTACK_n = 1'b1;
    checkOutput("rd_idle_busy", bif.busy, 0);
    @(negedge CLK);

    // Write, upper byte only, DTACK_n 4 clocks after AS_n falls; a req while busy is ignored
    applyStimulus(1'b0, 23'h000100, 16'h9000, 2'b10, 1'b1, 11, 16'hC0DE, 1'b0, 1'b0, c0);
    atCycle(c0 + 2);
    checkOutput("wr_assert_strobes", {AS_n, UDS_n, LDS_n}, 3'b011);
    checkOutput("wr_assert_dout_oe", DOUT_OE, 1);
    checkOutput("wr_assert_rw", RW, 0);
    checkOutput("wr_dout", DOUT, 16'h9000);
    atCycle(c0 + 3);
    checkOutput("wr_wait_strobes", {AS_n, UDS_n, LDS_n}, 3'b001);
    atCycle(c0 + 4);
    bif.req    = 1'b1;
    bif.req_rw = 1'b1;
    bif.req_be = 2'b11;
    atCycle(c0 + 5);
    bif.req = 1'b0;
    checkOutput("wr_busy", bif.busy, 1);
    atCycle(c0 + 6);
    DTACK_n = 1'b0;
    atCycle(c0 + 8);
    checkOutput("wr_still_waiting_as", AS_n, 0);
    atCycle(c0 + 10);
    checkOutput("wr_end_strobes", {AS_n, UDS_n, LDS_n}, 3'b111);
    checkOutput("wr_end_dout_oe", DOUT_OE, 1);
    atCycle(c0 + 11);
    checkOutput("wr_recover_dout_oe", DOUT_OE, 0);
    checkOutput("wr_recover_rw", RW, 1);
    DTACK_n = 1'b1;

    // BERR_n and DTACK_n together: bus error, one clock shorter, rdata kept
    DIN = 16'h1234;
    applyStimulus(1'b1, 23'h000200, 16'h0000, 2'b01, 1'b1, 7, 16'hC0DE, 1'b1, 1'b0, c0);
    atCycle(c0 + 2);
    checkOutput("berr_assert_strobes", {AS_n, UDS_n, LDS_n}, 3'b010);
    DTACK_n = 1'b0;
    BERR_n  = 1'b0;
    atCycle(c0 + 6);
    checkOutput("berr_end_as", AS_n, 1);
    atCycle(c0 + 7);
    DTACK_n = 1'b1;
    BERR_n  = 1'b1;
    atCycle(c0 + 9);

    // Zero byte enables: immediate ack, no strobe activity
    applyStimulus(1'b1, 23'h000300, 16'h0000, 2'b00, 1'b1, 1, 16'hC0DE, 1'b0, 1'b0, c0);
    atCycle(c0 + 1);
    checkOutput("be0_as", AS_n, 1);
    checkOutput("be0_addr_oe", ADDR_OE, 0);
    atCycle(c0 + 2);
    checkOutput("be0_as_after", AS_n, 1);
    checkOutput("be0_busy_after", bif.busy, 0);

    // RESET during WAIT aborts the cycle with no ack
    applyStimulus(1'b1, 23'h000400, 16'h0000, 2'b11, 1'b0, 0, 16'h0000, 1'b0, 1'b0, c0);
    atCycle(c0 + 3);
    checkOutput("rstw_wait_as", AS_n, 0);
    RESET = 1'b1;
    atCycle(c0 + 4);
    RESET = 1'b0;
    checkOutput("rstw_as", AS_n, 1);
    checkOutput("rstw_addr_oe", ADDR_OE, 0);
    checkOutput("rstw_busy", bif.busy, 0);
    checkOutput("rstw_rdata", bif.rdata, 0);
    atCycle(c0 + 12);
    checkOutput("rstw_stays_idle", {bif.busy, AS_n}, 2'b01);

    // Back-to-back reads after reset, second req on the clock after the first ack
    DTACK_n = 1'b0;
    DIN     = 16'hA5A5;
    atCycle(c0 + 15);
    applyStimulus(1'b1, 23'h000500, 16'h0000, 2'b11, 1'b1, 8, 16'hA5A5, 1'b0, 1'b0, c0);
    atCycle(c0 + 8);
    DIN = 16'h5A5A;
    applyStimulus(1'b1, 23'h000501, 16'h0000, 2'b11, 1'b1, 8, 16'h5A5A, 1'b0, 1'b0, c0);
    atCycle(c0 + 2);
    checkOutput("b2b_addr", ADDR, 23'h000501);
    atCycle(c0 + 8);
    DTACK_n = 1'b1;

`ifdef BUS_TIMEOUT_EN
    // No termination: 16 WAIT clocks then abort with err and tmo
    repeat (3) @(negedge CLK);
    applyStimulus(1'b1, 23'h000600, 16'h0000, 2'b11, 1'b1, 20, 16'h5A5A, 1'b1, 1'b1, c0);
    atCycle(c0 + 18);
    checkOutput("tmo_last_wait_as", AS_n, 0);
    atCycle(c0 + 19);
    checkOutput("tmo_end_as", AS_n, 1);
    atCycle(c0 + 20);
`endif

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge CLK);
    checkOutput("scoreboard_empty", exp_q.size(), 0);
    repeat (2) @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
